// File: rtl/shape_pkg.sv
// Shared types, field positions and FSM states for the shape_processor command sequencer.
package shape_pkg;

    typedef logic [1:0] shape_t;
    typedef logic [4:0] operation_t;

    localparam int SHAPE_LSB = 16;
    localparam int OP_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RESP
    } seq_state_e;

    // Builds the SFR word; every bit outside the two fields stays 0.
    function automatic logic [31:0] pack_cmd(input shape_t shape, input operation_t op);
        logic [31:0] word;
        word = '0;
        word[SHAPE_LSB +: 2] = shape;
        word[OP_LSB +: 5]    = op;
        return word;
    endfunction

endpackage

// File: rtl/shape_rr_arbiter.sv
// Round-robin arbiter with a last-winner pointer; the pointer moves to the current winner on advance.
module shape_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [1:0] last_idx;
    logic [1:0] win_idx;

    // Scan from farthest to nearest after the pointer so the nearest requester is written last and wins.
    always_comb begin
        winner  = '0;
        valid   = 1'b0;
        win_idx = last_idx;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (((int'(last_idx) + k) % NUM_REQ) == j)) begin
                    winner    = '0;
                    winner[j] = 1'b1;
                    valid     = 1'b1;
                    win_idx   = 2'(j);
                end
            end
        end
    end

    // Pointing at the last index after reset gives requester 0 top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx <= 2'(NUM_REQ - 1);
        end else if (advance && valid) begin
            last_idx <= win_idx;
        end
    end

endmodule

// File: rtl/shape_cmd_sequencer.sv
// Round-robin command sequencer in front of the shape_processor control SFR.
// Define SHAPE_SEQ_READBACK_EN to confirm every write with an SFR readback compare.
module shape_cmd_sequencer
    import shape_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_shape,
    input  logic [5*NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 ok,
    output logic                 write,
    output logic [31:0]          write_data,
    output logic                 read,
    input  logic [31:0]          read_data,
    input  logic                 error,
    output logic [7:0]           rej_cnt
);

    seq_state_e         state, next_state;
    shape_t             cap_shape, sel_shape;
    operation_t         cap_op, sel_op;
    logic [NUM_REQ-1:0] arb_req, winner;
    logic               arb_valid, advance, pass;
    logic               unused_bits;

    // While responding, the arbiter sees only the granted requester so the pointer lands on it.
    assign arb_req = (state == RESP) ? gnt : req;
    assign advance = (state == RESP);

    shape_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (advance),
        .winner  (winner),
        .valid   (arb_valid)
    );

    always_comb begin
        sel_shape = '0;
        sel_op    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner[j]) begin
                sel_shape = req_shape[2*j +: 2];
                sel_op    = req_op[5*j +: 5];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        write      = 1'b0;
        write_data = '0;
        read       = 1'b0;
        done       = '0;
        ok         = 1'b0;
        case (state)
            IDLE: if (arb_valid) next_state = WR;
            WR: begin
                write      = 1'b1;
                write_data = pack_cmd(cap_shape, cap_op);
`ifdef SHAPE_SEQ_READBACK_EN
                next_state = RD;
`else
                next_state = RESP;
`endif
            end
`ifdef SHAPE_SEQ_READBACK_EN
            RD: begin
                read       = 1'b1;
                next_state = RESP;
            end
`endif
            RESP: begin
                done       = gnt;
                ok         = pass;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Fields are frozen at grant so requesters may change their inputs mid-command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            cap_shape <= '0;
            cap_op    <= '0;
        end else if (state == IDLE && arb_valid) begin
            gnt       <= winner;
            cap_shape <= sel_shape;
            cap_op    <= sel_op;
        end else if (state == RESP) begin
            gnt <= '0;
        end
    end

`ifdef SHAPE_SEQ_READBACK_EN
    logic err_wr;

    // Shape 00 is an operation-only update, so its shape field is not compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_wr <= 1'b0;
            pass   <= 1'b0;
        end else begin
            if (state == WR) err_wr <= error;
            if (state == RD) begin
                pass <= (read_data[OP_LSB +: 5] == cap_op) && !err_wr && !error &&
                        ((cap_shape == 2'b00) || (read_data[SHAPE_LSB +: 2] == cap_shape));
            end
        end
    end

    assign unused_bits = ^{read_data[31:18], read_data[15:5]};
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (state == WR) begin
            pass <= !error;
        end
    end

    assign unused_bits = ^read_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_cnt <= '0;
        end else if (state == RESP && !pass && rej_cnt != 8'hFF) begin
            rej_cnt <= rej_cnt + 8'd1;
        end
    end

endmodule

// File: doc/shape_cmd_sequencer.md
# shape_cmd_sequencer

Sequencer in front of the `shape_processor` control SFR, which holds the current shape and operation. It accepts shape/operation update commands from up to four requesters and grants one at a time, round-robin. It drives the SFR write and then reads the register back to confirm the update. Each requester gets a per-command pass/fail result, and a saturating counter tracks rejected updates.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clk`  in  1: single clock; all logic on posedge.
- `req`  in  NUM_REQ: per-requester command request; level, held until `done`.
- `req_shape`  in  2*NUM_REQ: requester i shape at [2i+1:2i].
- `req_op`  in  5*NUM_REQ: requester i operation at [5i+4:5i].
- `gnt`  out  NUM_REQ: one-hot; the requester whose command is in flight.
- `done`  out  NUM_REQ: one-cycle pulse to the granted requester at completion.
- `ok`  out  1: result, valid only while any `done` bit is high.
- `write`  out  1: SFR write strobe.
- `write_data`  out  32: shape in [17:16], operation in [4:0], all other bits 0.
- `read`  out  1: SFR read strobe.
- `read_data`  in  32: SFR contents; combinational and valid in the same cycle `read` is high.
- `error`  in  1: processor error flag, sampled in WR and RD.
- `rej_cnt`  out  8: saturating count of commands completed with `ok`=0.

## Operation
- States are IDLE, WR, RD and RESP.
- **IDLE:** if any `req` bit is set, the arbiter picks a winner. The block captures that requester's shape and op into internal registers, sets `gnt`, and moves to WR.
- **WR:** `write`=1 for exactly one cycle with `write_data` built from the captured fields. Next state is RD.
- **RD:** `read`=1 for one cycle. The compare result is registered. Next state is RESP.
- **Compare rule:** pass requires `read_data[4:0]` == captured op, `error`=0 in both WR and RD, and, when captured shape != 0, `read_data[17:16]` == captured shape.
  - Shape 00 is an operation-only update, so the shape field is not compared.
- **RESP:** drive `done[winner]`=1 and `ok`. Clear `gnt`. If `ok`=0, increment `rej_cnt`, holding at 255. Return to IDLE.
- **Arbitration:** round-robin with a last-winner pointer. After reset the pointer favours requester 0. The pointer advances only in RESP.
- **Request handshake:**
  - The block never checks command legality; the processor decides, and a rejected write shows up as a readback mismatch.
  - The captured fields are immune to requester changes after grant.
  - A requester must drop `req` in the cycle after `done`. A `req` still high in IDLE is treated as a new command.
- **Bounds:** `req` bits with index >= NUM_REQ do not exist. Unused `write_data` bits are always 0.

## Timing
- Reset values: state IDLE, `gnt`=0, `done`=0, `ok`=0, `write`=0, `read`=0, `write_data`=0, `rej_cnt`=0, arbiter pointer at requester 0.
- Latency, with `req` seen in IDLE at cycle 0:
  - `write` at cycle 1, `read` at cycle 2, `done` at cycle 3.
  - Back-to-back commands: the next grant comes at cycle 4, giving one command per 4 cycles.
- `write` and `read` are never high together. `write_data` is 0 whenever `write`=0.
- Simultaneous requests: exactly one grant. Losers keep `req` high and are served in rotation.
- Reset asserted mid-command: the command is abandoned with no `done` pulse and all outputs return to reset values immediately. Requesters must re-issue.
- `rej_cnt` at 255 stays at 255.

## Configuration
- `SHAPE_SEQ_READBACK_EN` defined: full WR, RD, RESP sequence as described above.
- Not defined:
  - The RD state is removed: WR goes directly to RESP, `read` is tied to 0, and `read_data` is ignored.
  - `ok` = NOT `error` sampled in WR; the command-to-`done` latency is 2 cycles.
  - `rej_cnt` counts only error-flagged commands.

## Structure
- Shared package `shape_pkg`:
  - `shape_t` (2 bits) and `operation_t` (5 bits).
  - Constants `SHAPE_LSB`=16 and `OP_LSB`=0.
  - The state enum `seq_state_e`.
- Sub-module `shape_rr_arbiter`, parameterised by NUM_REQ:
  - Inputs: `req` and an `advance` strobe.
  - Outputs: one-hot `winner` and a `valid` flag.
- The sequencer itself contains the FSM, the capture registers, the compare logic and the counter.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs -> every output is 0 and the state is IDLE.
- **Legal command:** req0 with shape 01, op 00_001, `read_data` returning 0x0001_0001 -> `write_data`=0x0001_0001 at cycle 1, `read` at cycle 2, `done[0]` with `ok`=1 at cycle 3.
- **Concurrent requests:** req0 and req1 high from cycle 0 -> grant order 0, 1, 0 with `done` at cycles 3, 7, 11.
- **Illegal combination:** shape 01, op 10_000, `read_data` still holding the previous 0x0001_0000 -> `ok`=0 and `rej_cnt` increments from 0 to 1.
- **Operation-only update:** shape 00, op 01_000, `read_data`=0x0001_0008 -> `ok`=1, since shape is not compared.
- **Reset mid-command:** drop `rst_n` during RD -> no `done` pulse and all outputs return to 0. With `SHAPE_SEQ_READBACK_EN` undefined, the same legal command gives `done` at cycle 2 and `read` stays 0.
